decoder_2_to_4_reg: RTL and testbench
=====================================

# decoder_2_to_4_reg

Registered 2-to-4 line decoder with valid/ready handshaking: the receive-side counterpart of the 4-to-2 encoder. It accepts a 2-bit code plus a valid qualifier and drives the matching one-hot line through a one-entry output register, with backpressure. It also keeps per-line saturating event counters for debug readback. It sits downstream of the encoder in the same datapath and re-expands encoded selects into one-hot enables.

## Interface
Parameters:
- CNT_W, 8, width of each per-line event counter (legal range 2..16)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_code is meaningful this cycle (the encoder's valid)
- in_code  input  2  encoded line index (the encoder's Y)
- in_ready  output  1  stage can accept this cycle
- Y  output  4  one-hot decoded line; 4'b0000 whenever out_valid=0
- out_valid  output  1  Y holds a decoded value
- out_ready  input  1  downstream consumes Y this cycle
- cnt_sel  input  2  selects which line counter appears on cnt_value
- cnt_value  output  CNT_W  count of accepted codes for line cnt_sel
- cnt_clear  input  1  synchronous clear of all four counters

## Operation
- Reset is decided: one clock; reset is asynchronous and active-low. While rst_n=0:
  - Y=4'b0000, out_valid=0.
  - All counters are 0, so cnt_value=0.
  - in_ready=1, since it is derived from out_valid=0.
- Two-state FSM on out_valid:
  - EMPTY (out_valid=0) goes to FULL on accept.
  - FULL (out_valid=1) stays FULL on a simultaneous accept and consume, which reloads Y.
  - FULL goes to EMPTY on consume with no accept.
  - FULL holds on no consume.
- in_ready = !out_valid || out_ready. This is combinational pass-through of backpressure; no bubble.
- Accept = in_valid && in_ready. Consume = out_valid && out_ready.
- Decode on accept:
  - code 0 -> 4'b0001
  - code 1 -> 4'b0010
  - code 2 -> 4'b0100
  - code 3 -> 4'b1000
- Y and out_valid are stable while out_valid=1 and out_ready=0. Upstream changes to in_code while in_ready=0 must not affect Y.
- in_code is ignored when in_valid=0. This covers the encoder's no-input and multi-hot cases (valid=0, Y=00): nothing is produced and nothing is counted.
- Counters:
  - Counter[in_code] increments by 1 on each accept, independent of out_ready.
  - Each counter saturates at 2^CNT_W-1 and does not wrap.
  - cnt_clear=1 zeroes all four counters and takes priority over an increment in the same cycle.
- cnt_value = counter[cnt_sel], read combinationally from the registers.

## Timing
- Latency: an accept at edge N makes out_valid=1 and Y valid after edge N; Y is sampled by downstream at edge N+1 at the earliest.
- Throughput is 1 code/cycle while out_ready=1.
- in_ready responds to out_ready in the same cycle. There is no combinational path from in_valid or in_code to out_valid or Y.
- Counter updates are visible on cnt_value the cycle after the accept edge. A clear is visible the cycle after the clear edge.
- Changing cnt_sel updates cnt_value within the same cycle.
- Reset asserted mid-transfer: the held Y is dropped immediately, asynchronously, and counters are zeroed. There is no replay after rst_n deasserts.
- First accept: the earliest possible accept is the first rising edge where rst_n=1 is sampled.

## Test plan
- Reset check: drive rst_n=0 with in_valid=1 and in_code=2 -> Y=0000, out_valid=0, in_ready=1, cnt_value=0 for every cnt_sel.
- Streaming: with out_ready=1, send codes 0,1,2,3 on consecutive cycles -> Y=0001,0010,0100,1000 on consecutive cycles, each one cycle after its accept. Afterwards counters read 1,1,1,1.
- Backpressure: send code 3, hold out_ready=0 for 5 cycles, and change in_code to 1 meanwhile:
  - During the stall: Y=1000 held, in_ready=0, no change to counters.
  - Then raise out_ready and offer code 1 -> consume of 1000 and accept of 1 in the same cycle, next Y=0010.
- Invalid gating: in_valid=0 with in_code=2 for 10 cycles -> out_valid stays 0 and counter[2] stays 0.
- Saturation and clear: with CNT_W=2, accept code 1 six times -> cnt_value saturates at 3. Then assert cnt_clear together with a code-1 accept -> counter[1]=0 next cycle.
- Reset mid-operation: with out_valid=1, Y=0100 and counter[2]=5, pulse rst_n low between clock edges -> Y=0000, out_valid=0 and counters 0 immediately, and no output appears after release until a new accept.

Source files
------------

// File: rtl/decoder_2_to_4_reg_if.sv
// Handshake, decode and counter-readback signals between the encoder side,
// the decoder stage and the downstream consumer.
interface decoder_2_to_4_reg_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic [1:0]       in_code;
  logic             in_ready;
  logic [3:0]       Y;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       cnt_sel;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_clear;

  modport master (
    output in_valid, in_code, out_ready, cnt_sel, cnt_clear,
    input  in_ready, Y, out_valid, cnt_value
  );

  modport slave (
    input  in_valid, in_code, out_ready, cnt_sel, cnt_clear,
    output in_ready, Y, out_valid, cnt_value
  );
endinterface

// File: rtl/decoder_2_to_4_reg.sv
// Registered 2-to-4 decoder with a one-entry valid/ready output stage and
// per-line saturating accept counters for debug readback.
module decoder_line_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0] r_cnt;

  // Clear wins over a same-cycle increment; all-ones is sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_cnt <= '0;
    else if (i_clr)                  r_cnt <= '0;
    else if (i_inc && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
  end

  assign o_cnt = r_cnt;
endmodule

module decoder_2_to_4_reg #(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  decoder_2_to_4_reg_if.slave  bus
);
  localparam int NUM_LANES = 4;
  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [0:0]                        r_state;
  logic [3:0]                        r_y;
  logic                              w_in_ready;
  logic                              w_accept;
  logic                              w_consume;
  logic [NUM_LANES-1:0]              w_inc;
  logic [NUM_LANES-1:0][CNT_W-1:0]   w_cnt;

  // Backpressure passes straight through so a full stage never bubbles.
  assign w_in_ready = (r_state == S_EMPTY) || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_consume  = (r_state == S_FULL) && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: if (w_accept)                r_state <= S_FULL;
        S_FULL:  if (w_consume && !w_accept)  r_state <= S_EMPTY;
        default:                              r_state <= S_EMPTY;
      endcase
    end
  end

  // r_y is kept zero while empty so Y needs no output gating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_y <= 4'b0000;
    else if (w_accept)  r_y <= 4'b0001 << bus.in_code;
    else if (w_consume) r_y <= 4'b0000;
  end

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_line
      assign w_inc[g] = w_accept && (bus.in_code == 2'(g));
      decoder_line_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_inc[g]),
        .i_clr (bus.cnt_clear),
        .o_cnt (w_cnt[g])
      );
    end
  endgenerate

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == S_FULL);
  assign bus.Y         = r_y;
  assign bus.cnt_value = w_cnt[bus.cnt_sel];
endmodule

// File: tb/tb_decoder_2_to_4_reg.sv
// Directed bench: stimulus pushes expected Y per accept; a negedge monitor
// pops and compares on every consume. A CNT_W=2 instance covers saturation.
module tb_decoder_2_to_4_reg;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  decoder_2_to_4_reg_if #(.CNT_W(8)) bus ();
  decoder_2_to_4_reg_if #(.CNT_W(2)) sbus ();

  decoder_2_to_4_reg #(.CNT_W(8)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  decoder_2_to_4_reg #(.CNT_W(2)) u_sat (.clk(clk), .rst_n(rst_n), .bus(sbus.slave));

  int vectors = 0;
  int miscompares = 0;
  logic [3:0] q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every consume must match the oldest outstanding accept.
  initial begin
    logic [3:0] e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (bus.out_valid && bus.out_ready) begin
          if (q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_out: Y=%b with no pending accept", bus.Y);
          end else begin
            e = q.pop_front();
            chk("Y_consume", 32'(bus.Y), 32'(e));
          end
        end else if (!bus.out_valid) begin
          chk("Y_idle", 32'(bus.Y), 32'h0);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b1; bus.in_code = 2'd2; bus.out_ready = 1'b0;
    bus.cnt_sel = 2'd0;  bus.cnt_clear = 1'b0;
    sbus.in_valid = 1'b0; sbus.in_code = 2'd0; sbus.out_ready = 1'b1;
    sbus.cnt_sel = 2'd1;  sbus.cnt_clear = 1'b0;

    // Reset state, with a valid code pending upstream
    tick(); tick();
    chk("rst_Y", 32'(bus.Y), 32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
    for (int s = 0; s < 4; s++) begin
      bus.cnt_sel = 2'(s);
      #1 chk("rst_cnt", 32'(bus.cnt_value), 32'h0);
    end
    bus.in_valid = 1'b0;
    tick();
    rst_n = 1'b1;

    // Streaming codes 0..3 back to back
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      bus.in_valid = 1'b1;
      bus.in_code  = 2'(c);
      q.push_back(4'b0001 << c);
      tick();
      chk("stream_Y", 32'(bus.Y), 32'(4'b0001 << c));
    end
    bus.in_valid = 1'b0;
    tick(); tick();
    for (int s = 0; s < 4; s++) begin
      bus.cnt_sel = 2'(s);
      #1 chk("stream_cnt", 32'(bus.cnt_value), 32'h1);
    end

    // Backpressure: hold 1000, upstream switches to code 1 meanwhile
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_code   = 2'd3;
    q.push_back(4'b1000);
    tick();
    bus.in_code = 2'd1;
    bus.cnt_sel = 2'd1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_Y", 32'(bus.Y), 32'h8);
      chk("stall_in_ready", 32'(bus.in_ready), 32'h0);
      chk("stall_cnt1", 32'(bus.cnt_value), 32'h1);
      tick();
    end
    bus.out_ready = 1'b1;
    q.push_back(4'b0010);
    #1 chk("release_in_ready", 32'(bus.in_ready), 32'h1);
    tick();
    bus.in_valid = 1'b0;
    chk("reload_Y", 32'(bus.Y), 32'h2);
    chk("reload_cnt1", 32'(bus.cnt_value), 32'h2);
    tick(); tick();

    // Invalid gating
    bus.in_valid = 1'b0;
    bus.in_code  = 2'd2;
    bus.cnt_sel  = 2'd2;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("gate_out_valid", 32'(bus.out_valid), 32'h0);
    end
    chk("gate_cnt2", 32'(bus.cnt_value), 32'h1);

    // Saturation and clear priority on the 2-bit instance
    sbus.in_valid = 1'b1;
    sbus.in_code  = 2'd1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("sat_cnt", 32'(sbus.cnt_value), (k < 3) ? k : 3);
    end
    chk("sat_Y", 32'(sbus.Y), 32'h2);
    sbus.cnt_clear = 1'b1;
    tick();
    chk("clear_cnt", 32'(sbus.cnt_value), 32'h0);
    sbus.cnt_clear = 1'b0;
    sbus.in_valid  = 1'b0;
    tick();
    chk("clear_hold", 32'(sbus.cnt_value), 32'h0);

    // Reset mid-operation: build counter[2]=5 with 0100 held
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_code  = 2'd2;
      q.push_back(4'b0100);
      tick();
    end
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    #1;
    chk("pre_rst_Y", 32'(bus.Y), 32'h4);
    chk("pre_rst_valid", 32'(bus.out_valid), 32'h1);
    chk("pre_rst_cnt2", 32'(bus.cnt_value), 32'h5);
    rst_n = 1'b0;
    #1;
    chk("async_rst_Y", 32'(bus.Y), 32'h0);
    chk("async_rst_valid", 32'(bus.out_valid), 32'h0);
    chk("async_rst_cnt2", 32'(bus.cnt_value), 32'h0);
    q.delete();
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("no_replay", 32'(bus.out_valid), 32'h0);
    end
    bus.in_valid = 1'b1;
    bus.in_code  = 2'd0;
    q.push_back(4'b0001);
    tick();
    bus.in_valid = 1'b0;
    tick(); tick();
    chk("queue_drained", 32'(q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
